// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: 50% duty clk_out (odd N stretched by a
// negedge stage), one-cycle tick per period, divisor changes staged to the period boundary.
module clk_div_prog #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      cfg_valid,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    output logic                      cfg_ready,
    output logic                      cfg_err,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick
);

    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned CH_SPAN = 1 << CH_W;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] a_q, a_d;
    logic [NUM_CH-1:0] b_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [DIV_W-1:0]  cnt_q  [NUM_CH];
    logic [DIV_W-1:0]  cnt_d  [NUM_CH];
    logic [DIV_W-1:0]  div_q  [NUM_CH];
    logic [DIV_W-1:0]  div_d  [NUM_CH];
    logic [DIV_W-1:0]  pdiv_q [NUM_CH];
    logic [DIV_W-1:0]  pdiv_d [NUM_CH];
    logic              cfg_err_q, cfg_err_d;
    logic              init_q;

    logic [CH_SPAN-1:0] ch_ok_vec;
    logic [CH_SPAN-1:0] pend_ext;
    logic               ch_ok;
    logic               div_ok;
    logic               cfg_fire;
    logic [NUM_CH-1:0]  wrap_c;
    logic [NUM_CH-1:0]  apply_c;

    // Config decode: channel range, divisor legality and handshake.
    always_comb begin
        ch_ok_vec = '0;
        for (int unsigned i = 0; i < CH_SPAN; i++) begin
            ch_ok_vec[i] = (i < NUM_CH);
        end
        pend_ext  = CH_SPAN'(pend_q);
        ch_ok     = ch_ok_vec[cfg_ch];
        div_ok    = (cfg_div > DIV_W'(1));
        cfg_ready = init_q & (~ch_ok | ~pend_ext[cfg_ch]);
        cfg_fire  = cfg_valid & cfg_ready;
        cfg_err_d = cfg_fire & ~(ch_ok & div_ok);
    end

    // Per-channel next state; outputs are registered from next-state values.
    always_comb begin
        wrap_c  = '0;
        apply_c = '0;
        run_d   = ch_en;
        pend_d  = pend_q;
        a_d     = '0;
        tick_d  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = '0;
            div_d[i]  = div_q[i];
            pdiv_d[i] = pdiv_q[i];

            wrap_c[i]  = run_q[i] && (cnt_q[i] == (div_q[i] - DIV_W'(1)));
            apply_c[i] = pend_q[i] && (!run_q[i] || wrap_c[i]);
            if (apply_c[i]) begin
                div_d[i]  = pdiv_q[i];
                pend_d[i] = 1'b0;
            end
            if (cfg_fire && ch_ok && div_ok && (cfg_ch == CH_W'(i))) begin
                pend_d[i] = 1'b1;
                pdiv_d[i] = cfg_div;
            end

            if (run_q[i] && run_d[i] && !wrap_c[i]) begin
                cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
            a_d[i]    = run_d[i] && (cnt_d[i] < (div_d[i] >> 1));
            tick_d[i] = run_d[i] && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= '0;
            a_q       <= '0;
            pend_q    <= '0;
            tick_q    <= '0;
            cfg_err_q <= 1'b0;
            init_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= DIV_RST;
                pdiv_q[i] <= '0;
            end
        end else begin
            run_q     <= run_d;
            a_q       <= a_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
            init_q    <= 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pdiv_q[i] <= pdiv_d[i];
            end
        end
    end

    // Half-cycle stage that stretches the high phase for odd divisors.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            b_q <= '0;
        end else begin
            b_q <= a_q;
        end
    end

    always_comb begin
        clk_out = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            clk_out[i] = a_q[i] | (b_q[i] & div_q[i][0]);
        end
    end

    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: per-channel period/phase model checked every half cycle,
// plus directed scenarios with hand-computed periods, pulse widths and handshakes.
module tb_clk_div_prog;

    localparam int NCH = 4;
    localparam int DW  = 26;
    localparam int DEF = 4;

    logic            clk;
    logic            reset;
    logic [NCH-1:0]  ch_en;
    logic            cfg_valid;
    logic [1:0]      cfg_ch;
    logic [DW-1:0]   cfg_div;
    logic            cfg_ready;
    logic            cfg_err;
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  tick;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  chk_on  = 1'b0;

    // Model: whether running, position within the current period, divisor, staged divisor.
    int  m_run  [NCH];
    int  m_pos  [NCH];
    int  m_div  [NCH];
    int  m_pend [NCH];
    int  m_pdiv [NCH];
    bit  m_aprev[NCH];
    bit  m_err;
    bit  m_init;

    time rise_t = 0, fall_t = 0, hi_t = 0, lo_t = 0;

    clk_div_prog #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .reset(reset), .ch_en(ch_en), .cfg_valid(cfg_valid),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
        .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // High phase of a period: the first floor(N/2) cycles.
    function automatic bit m_a(input int i);
        return (m_run[i] != 0) && (m_pos[i] < m_div[i] / 2);
    endfunction

    function automatic bit m_rdy();
        return m_init && (m_pend[int'(cfg_ch)] == 0);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_div[i] = DEF;
            m_pend[i] = 0; m_pdiv[i] = 0; m_aprev[i] = 1'b0;
        end
        m_err  = 1'b0;
        m_init = 1'b0;
    endtask

    task automatic m_step();
        bit rdy;
        bit wrap;
        rdy   = m_rdy();
        m_err = cfg_valid && rdy && (int'(cfg_div) < 2);
        for (int i = 0; i < NCH; i++) begin
            m_aprev[i] = m_a(i);
            wrap = (m_run[i] != 0) && (m_pos[i] == m_div[i] - 1);
            if (m_pend[i] != 0 && (m_run[i] == 0 || wrap)) begin
                m_div[i]  = m_pdiv[i];
                m_pend[i] = 0;
            end
            if (cfg_valid && rdy && int'(cfg_ch) == i && int'(cfg_div) >= 2) begin
                m_pend[i] = 1;
                m_pdiv[i] = int'(cfg_div);
            end
            m_pos[i] = (m_run[i] != 0 && ch_en[i] && !wrap) ? m_pos[i] + 1 : 0;
            m_run[i] = ch_en[i] ? 1 : 0;
        end
        m_init = 1'b1;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_reset();
            else        m_step();
        end
    end

    initial forever begin
        @(posedge clk_out[1]);
        lo_t   = $time - fall_t;
        rise_t = $time;
    end

    initial forever begin
        @(negedge clk_out[1]);
        hi_t   = $time - rise_t;
        fall_t = $time;
    end

    // Every half cycle: first half may carry the odd-N stretch, second half is the plain high phase.
    initial forever begin
        @(posedge clk); #1;
        if (chk_on && reset) begin
            for (int i = 0; i < NCH; i++) begin
                check($sformatf("tick[%0d]", i), 64'(tick[i]),
                      64'((m_run[i] != 0) && (m_pos[i] == 0)));
                check($sformatf("clk_out_lead[%0d]", i), 64'(clk_out[i]),
                      64'(m_a(i) | (m_aprev[i] & (m_div[i] % 2 == 1))));
            end
            check("cfg_err", 64'(cfg_err), 64'(m_err));
        end
        @(negedge clk); #1;
        if (chk_on && reset) begin
            for (int i = 0; i < NCH; i++) begin
                check($sformatf("clk_out_trail[%0d]", i), 64'(clk_out[i]), 64'(m_a(i)));
            end
            check("cfg_ready", 64'(cfg_ready), 64'(m_rdy()));
        end
    end

    task automatic cfg_write(input int ch, input int dv);
        int k;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = DW'(dv);
        for (k = 0; k < 64; k++) begin
            #1;
            if (cfg_ready) break;
            @(negedge clk);
        end
        if (k == 64) begin
            n_tests++;
            n_fail++;
            $display("FAIL cfg_write ch%0d: cfg_ready stayed 0 for 64 cycles, expected 1", ch);
        end
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input int ch, output int at);
        at = -1;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            if (tick[ch]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_tick[%0d]: no tick within 64 cycles, expected one", ch);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        bit pc[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bit pt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int t0, t1, t2, t3;

        reset = 1'b0; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        #5;
        check("reset clk_out", 64'(clk_out), 64'd0);
        check("reset tick", 64'(tick), 64'd0);
        check("reset cfg_err", 64'(cfg_err), 64'd0);
        @(negedge clk);
        reset  = 1'b1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        check("cfg_ready after reset", 64'(cfg_ready), 64'd1);

        // N=4 from reset: 2 high / 2 low, tick every 4, first tick one cycle after enable
        @(negedge clk);
        ch_en[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("n4 clk_out[0] c%0d", k), 64'(clk_out[0]), 64'(pc[k]));
            check($sformatf("n4 tick[0] c%0d", k), 64'(tick[0]), 64'(pt[k]));
        end

        // N=5 on idle ch1: 100-unit period, 50 high / 50 low
        cfg_write(1, 5);
        ch_en[1] = 1'b1;
        wait_tick(1, t0);
        wait_tick(1, t1);
        wait_tick(1, t2);
        check("n5 period a", 64'(t1 - t0), 64'd5);
        check("n5 period b", 64'(t2 - t1), 64'd5);
        check("n5 high time", 64'(hi_t), 64'd50);
        check("n5 low time", 64'(lo_t), 64'd50);

        // ch0 at N=8, then write N=3 while cnt=2: period 8 completes, then 3
        cfg_write(0, 8);
        wait_tick(0, t0);
        wait_tick(0, t0);
        @(negedge clk);
        @(negedge clk);
        cfg_write(0, 3);
        wait_tick(0, t1);
        wait_tick(0, t2);
        wait_tick(0, t3);
        check("n8->3 old period", 64'(t1 - t0), 64'd8);
        check("n8->3 new period a", 64'(t2 - t1), 64'd3);
        check("n8->3 new period b", 64'(t3 - t2), 64'd3);

        // Illegal divisors rejected with a one-cycle error pulse
        cfg_write(0, 1);
        #1 check("err N=1 pulse", 64'(cfg_err), 64'd1);
        @(posedge clk); #1;
        check("err N=1 end", 64'(cfg_err), 64'd0);
        cfg_write(0, 0);
        #1 check("err N=0 pulse", 64'(cfg_err), 64'd1);
        @(posedge clk); #1;
        check("err N=0 end", 64'(cfg_err), 64'd0);
        wait_tick(0, t0);
        wait_tick(0, t1);
        check("period after rejects", 64'(t1 - t0), 64'd3);

        // ch2: second write stalls until the first is applied at the wrap
        @(negedge clk);
        ch_en[2] = 1'b1;
        wait_tick(2, t0);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = DW'(6);
        #1 check("ch2 first ready", 64'(cfg_ready), 64'd1);
        @(negedge clk);
        cfg_div = DW'(7);
        #1 check("ch2 pend ready pos1", 64'(cfg_ready), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            check($sformatf("ch2 pend ready pos%0d", k + 2), 64'(cfg_ready), 64'd0);
        end
        @(negedge clk); #1;
        check("ch2 ready at wrap", 64'(cfg_ready), 64'd1);
        check("ch2 tick at wrap", 64'(tick[2]), 64'd1);
        t1 = cyc;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_tick(2, t2);
        wait_tick(2, t3);
        check("ch2 period 6", 64'(t2 - t1), 64'd6);
        check("ch2 period 7", 64'(t3 - t2), 64'd7);

        // ch3 N=5: disable mid-high, output low within one clock
        cfg_write(3, 5);
        ch_en[3] = 1'b1;
        wait_tick(3, t0);
        @(negedge clk);
        ch_en[3] = 1'b0;
        #1 check("ch3 high before disable", 64'(clk_out[3]), 64'd1);
        @(posedge clk); #1;
        check("ch3 no tick after disable", 64'(tick[3]), 64'd0);
        @(negedge clk); #1;
        check("ch3 low after disable", 64'(clk_out[3]), 64'd0);

        // Asynchronous reset mid-period
        @(posedge clk);
        #5 reset = 1'b0;
        #1;
        check("async reset clk_out", 64'(clk_out), 64'd0);
        check("async reset tick", 64'(tick), 64'd0);
        check("async reset cfg_err", 64'(cfg_err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_tick(0, t0);
        wait_tick(0, t1);
        check("default period after reset", 64'(t1 - t0), 64'd4);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
